// File: rtl/inv_addkey_mixcol_pkg.sv
// Shared AES types, FSM encoding, column access helpers and GF(2^8) arithmetic
// for the decryption round back-end.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [1:0]   col_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } inv_mix_fsm_e;

  // Column 0 occupies the most significant word of the state.
  function automatic aes_word_t get_col(input aes_state_t s, input col_idx_t idx);
    aes_word_t w;
    w = s[127:96];
    case (idx)
      2'd1:    w = s[95:64];
      2'd2:    w = s[63:32];
      2'd3:    w = s[31:0];
      default: w = s[127:96];
    endcase
    return w;
  endfunction

  function automatic aes_state_t put_col(input aes_state_t s, input col_idx_t idx,
                                         input aes_word_t w);
    aes_state_t r;
    r = s;
    case (idx)
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      2'd3:    r[31:0]   = w;
      default: r[127:96] = w;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; enough for the InvMixColumns coefficients.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_addkey_mixcol_if.sv
// Input/output handshake bundle of the AddRoundKey + InvMixColumns stage.
interface inv_addkey_mixcol_if;
  import aes_pkg::*;

  logic       in_valid_i;
  logic       in_ready_o;
  aes_state_t state_i;
  aes_state_t key_i;
  logic       skip_mix_i;
  logic       out_valid_o;
  logic       out_ready_i;
  aes_state_t state_o;

  modport master (
    output in_valid_i, state_i, key_i, skip_mix_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o
  );

  modport slave (
    input  in_valid_i, state_i, key_i, skip_mix_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o
  );
endinterface

// File: rtl/inv_addkey_mixcol_inv_mixw.sv
// InvMixColumns on a single 32-bit column; byte b0 is the most significant byte.
module inv_mixw
  import aes_pkg::*;
(
  input  aes_word_t din,
  output aes_word_t dout
);
  logic [7:0] a [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign a[gi] = din[31-8*gi -: 8];
      // Each output row is the circulant {0e,0b,0d,09} rotated by its index.
      assign dout[31-8*gi -: 8] = gmul(a[gi], 4'he)
                                ^ gmul(a[(gi+1)%4], 4'hb)
                                ^ gmul(a[(gi+2)%4], 4'hd)
                                ^ gmul(a[(gi+3)%4], 4'h9);
    end
  endgenerate
endmodule

// File: rtl/inv_addkey_mixcol.sv
// AES decryption round back-end: AddRoundKey, then InvMixColumns one column per
// cycle through a single shared inv_mixw, with valid/ready on both sides.
module inv_addkey_mixcol
  import aes_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  inv_addkey_mixcol_if.slave   bus
);
  inv_mix_fsm_e fsm_reg, fsm_next;
  col_idx_t     col_reg, col_next;
  aes_state_t   state_reg, state_next;
  aes_word_t    mix_in, mix_out;
  logic         accept;

  assign bus.in_ready_o  = (fsm_reg == IDLE) | ((fsm_reg == DONE) & bus.out_ready_i);
  assign bus.out_valid_o = (fsm_reg == DONE);
  assign bus.state_o     = state_reg;
  assign accept          = bus.in_valid_i & bus.in_ready_o;

  assign mix_in = get_col(state_reg, col_reg);

  inv_mixw u_mixw (
    .din  (mix_in),
    .dout (mix_out)
  );

  always_comb begin
    fsm_next   = fsm_reg;
    col_next   = col_reg;
    state_next = state_reg;
    case (fsm_reg)
      MIX: begin
        state_next = put_col(state_reg, col_reg, mix_out);
        col_next   = col_reg + 2'd1;
        if (col_reg == 2'd3) fsm_next = DONE;
      end
      DONE: begin
        if (bus.out_ready_i) fsm_next = IDLE;
      end
      IDLE: ;
      default: fsm_next = IDLE;
    endcase
    // Acceptance can only happen in IDLE or in DONE while the output drains.
    if (accept) begin
      state_next = bus.state_i ^ bus.key_i;
      col_next   = 2'd0;
      fsm_next   = bus.skip_mix_i ? DONE : MIX;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_reg   <= IDLE;
      col_reg   <= 2'd0;
      state_reg <= '0;
    end else begin
      fsm_reg   <= fsm_next;
      col_reg   <= col_next;
      state_reg <= state_next;
    end
  end
endmodule

// File: tb/tb_inv_addkey_mixcol.sv
// Directed bench for inv_addkey_mixcol: known-answer vectors, handshake stalls,
// back-to-back accept, mid-block reset and ignored input pulses.
module tb_inv_addkey_mixcol;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inv_addkey_mixcol_if bus ();

  inv_addkey_mixcol dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int blk = 0;
  aes_state_t sb[$];

  localparam aes_state_t V1_IN  = {4{32'h8e4da1bc}};
  localparam aes_state_t V1_OUT = {4{32'hdb135345}};
  localparam aes_state_t V2_IN  = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc};
  localparam aes_state_t V2_OUT = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345};
  localparam aes_state_t V3_IN  = 128'h0123456789abcdeffedcba9876543210;
  localparam aes_state_t ONES   = {128{1'b1}};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic send(input aes_state_t s, input aes_state_t k, input logic skip,
                      input aes_state_t exp);
    bus.state_i    = s;
    bus.key_i      = k;
    bus.skip_mix_i = skip;
    bus.in_valid_i = 1'b1;
    #1 check("send_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
    sb.push_back(exp);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    bus.state_i    = {$urandom, $urandom, $urandom, $urandom};
    bus.key_i      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts falling edges after the accept edge until out_valid, then scores state_o.
  task automatic wait_out(input int start, input int exp_lat, input string tag);
    int lat;
    aes_state_t exp;
    lat = start;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid_o && lat < 30);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    check({tag, "_state"}, bus.state_o, exp);
    blk++;
    $display("block %0d %s lat=%0d state_o=%h", blk, tag, lat, bus.state_o);
  endtask

  task automatic retire();
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.out_ready_i = 1'b0;
    @(negedge clk);
    check("retire_valid_low", 128'(bus.out_valid_o), 128'(1'b0));
  endtask

  initial begin
    aes_state_t held;
    int stray;
    rst = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.skip_mix_i  = 1'b0;
    bus.state_i     = '0;
    bus.key_i       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
    check("reset_out_valid", 128'(bus.out_valid_o), 128'(1'b0));
    check("reset_state_o", bus.state_o, '0);
    rst = 1'b0;
    @(negedge clk);

    // 1: uniform columns through InvMixColumns
    send(V1_IN, '0, 1'b0, V1_OUT);
    wait_out(0, 5, "t1_mix");
    retire();

    // 2: four distinct columns
    send(V2_IN, '0, 1'b0, V2_OUT);
    wait_out(0, 5, "t2_mix");
    retire();

    // 3: AddRoundKey only
    send(V3_IN, ONES, 1'b1, ~V3_IN);
    wait_out(0, 1, "t3_skip");
    retire();

    // 4: downstream stall, then back-to-back accept
    send(V3_IN, V2_IN, 1'b1, V3_IN ^ V2_IN);
    wait_out(0, 1, "t4_skip");
    held = V3_IN ^ V2_IN;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 128'(bus.out_valid_o), 128'(1'b1));
      check("t4_hold_state", bus.state_o, held);
      check("t4_hold_in_ready", 128'(bus.in_ready_o), 128'(1'b0));
    end
    bus.out_ready_i = 1'b1;
    send(V1_IN, '0, 1'b0, V1_OUT);
    bus.out_ready_i = 1'b0;
    wait_out(0, 5, "t4_b2b");
    retire();

    // 5: reset during the second MIX cycle aborts the block
    send(V2_IN, '0, 1'b0, V2_OUT);
    void'(sb.pop_back());
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 128'(bus.out_valid_o), 128'(1'b0));
    check("t5_rst_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
    check("t5_rst_state_o", bus.state_o, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(V2_IN, '0, 1'b0, V2_OUT);
    wait_out(0, 5, "t5_after_rst");
    retire();

    // 6: a valid pulse during MIX is dropped
    send(V1_IN, '0, 1'b0, V1_OUT);
    @(negedge clk);
    bus.state_i    = V3_IN;
    bus.key_i      = '0;
    bus.skip_mix_i = 1'b1;
    bus.in_valid_i = 1'b1;
    #1 check("t6_in_ready_mix", 128'(bus.in_ready_o), 128'(1'b0));
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    wait_out(2, 5, "t6_ignore");
    retire();
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid_o) stray++;
    end
    check("t6_no_extra_output", 128'(stray), 128'(0));
    check("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
